// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if
//   Handshake/operand bundle for the shift-and-add multiplier controller.
//   master (requester): drives start, a, b; receives product, busy, done.
//   slave  (controller): receives start, a, b; drives product, busy, done.
//   WIDTH : operand width; product is 2*WIDTH bits.
interface shift_add_mult_if #(
    parameter int WIDTH = 3
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    modport master (output start, a, b, input product, busy, done);
    modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
//   Sequencing controller for a multi-cycle unsigned shift-and-add multiplier.
//   A start seen while idle latches both operands; the accumulator then adds
//   one shifted partial product per clock for WIDTH clocks. The result is
//   registered into product together with a one-cycle done pulse, followed by
//   one DONE cycle before returning to idle.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : synchronous active-low reset, priority over everything
//     bus   : slave side of shift_add_mult_if (start/a/b in, product/busy/done out)
module shift_add_mult_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_add_mult_if.slave  bus
);
    // count only has to reach WIDTH-1; keep at least one bit.
    localparam int CW = (WIDTH < 3) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;
        // Partial product for the current multiplier LSB, weighted by step.
        addend    = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
        acc_next  = acc_q + addend;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_next;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // Last step: publish the sum including this step's addend.
                if (count_q == LAST) begin
                    product_d = acc_next;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.product = product_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl
//   Directed self-checking bench for shift_add_mult_ctrl at WIDTH=3.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_shift_add_mult_ctrl;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   fails;
    int   dones;
    int   ops;

    shift_add_mult_if #(.WIDTH(W)) bus ();

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen at a rising edge.
    always @(posedge clk) begin
        if (bus.done === 1'b1) dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One multiply with full timing checks; a/b scrambled right after accept.
    task automatic mult(input int ia, input int ib);
        int n;
        logic [2*W-1:0] exp;
        exp = (2*W)'(ia * ib);
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_start", {31'b0, bus.busy}, 0);
        bus.start = 1'b1;
        bus.a     = ia[W-1:0];
        bus.b     = ib[W-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        chk("busy_after_accept", {31'b0, bus.busy}, 1);
        for (int k = 0; k < W; k++) begin
            chk("done_early", {31'b0, bus.done}, 0);
            @(negedge clk);
        end
        chk("done_pulse", {31'b0, bus.done}, 1);
        chk("product", {26'b0, bus.product}, {26'b0, exp});
        chk("busy_in_done", {31'b0, bus.busy}, 1);
        @(negedge clk);
        chk("done_single", {31'b0, bus.done}, 0);
        chk("busy_fall", {31'b0, bus.busy}, 0);
        chk("product_hold", {26'b0, bus.product}, {26'b0, exp});
        ops++;
    endtask

    initial begin
        int n;
        total = 0; fails = 0; dones = 0; ops = 0;

        // Reset with start asserted: outputs stay cleared.
        rst_n = 1'b0; bus.start = 1'b1; bus.a = 3'd7; bus.b = 3'd7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_product", {26'b0, bus.product}, 0);
            chk("rst_busy", {31'b0, bus.busy}, 0);
            chk("rst_done", {31'b0, bus.done}, 0);
        end
        rst_n = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, bus.busy}, 0);

        // Basic and extremes.
        mult(5, 6);
        mult(0, 7);
        mult(7, 0);
        mult(7, 7);

        // Busy-ignore: 7*7 requests held during CALC/DONE must not disturb 3*3.
        bus.start = 1'b1; bus.a = 3'd3; bus.b = 3'd3;
        @(negedge clk);
        bus.a = 3'd7; bus.b = 3'd7;
        for (int k = 0; k < W; k++) begin
            chk("bi_done_early", {31'b0, bus.done}, 0);
            chk("bi_busy", {31'b0, bus.busy}, 1);
            @(negedge clk);
        end
        chk("bi_done1", {31'b0, bus.done}, 1);
        chk("bi_first_result", {26'b0, bus.product}, 9);
        n = 0;
        while (bus.busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        chk("bi_busy_dropped", {31'b0, bus.busy}, 0);
        n = 0;
        while (bus.busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("bi_reaccepted", {31'b0, bus.busy}, 1);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("bi_done2", {31'b0, bus.done}, 1);
        chk("bi_second_result", {26'b0, bus.product}, 49);
        ops += 2;
        @(negedge clk);

        // Abort: reset sampled two edges after accepting 6*5.
        bus.start = 1'b1; bus.a = 3'd6; bus.b = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_product", {26'b0, bus.product}, 0);
        chk("abort_busy", {31'b0, bus.busy}, 0);
        chk("abort_done", {31'b0, bus.done}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, bus.done}, 0);
            chk("abort_product_hold", {26'b0, bus.product}, 0);
        end
        mult(2, 3);

        // Exhaustive back-to-back.
        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                mult(ia, ib);

        @(negedge clk);
        chk("done_count", dones, ops);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
